// File: rtl/spec_peak_scan_ctrl.sv
// Spectrum RAM read sequencer: one linear sweep over the single-sided bins,
// tracking the two strongest peaks that are at least MIN_SEP bins apart.
module spec_peak_scan_ctrl #(
  parameter int END_BIN   = 2048,
  parameter int START_BIN = 5,
  parameter int MIN_SEP   = 8,
  parameter int RD_LAT    = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wr_done_i,
  output logic        rd_en_o,
  output logic [11:0] rd_addr_o,
  input  logic [15:0] rd_data_i,
  output logic [11:0] peak1_addr_o,
  output logic [15:0] peak1_amp_o,
  output logic [11:0] peak2_addr_o,
  output logic [15:0] peak2_amp_o,
  output logic        busy_o,
  output logic        sep_done_o
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

  state_e      state_q;
  logic        wr_done_q, rd_en_q, busy_q, sep_done_q;
  logic [11:0] rd_addr_q;
  logic [11:0] addr1_q, addr2_q, addr1_d, addr2_d;
  logic [15:0] amp1_q, amp2_q, amp1_d, amp2_d;
  logic [11:0] p1a_q, p2a_q;
  logic [15:0] p1v_q, p2v_q;

  // Stage i holds the valid/bin tag of the address issued i cycles ago;
  // stage RD_LAT lines up with rd_data_i.
  logic [RD_LAT:1]       vld_pipe;
  logic [RD_LAT:1][11:0] tag_pipe;

  logic [11:0] smp_bin, bin_dist;
  logic        sep_ok, inflight;

  assign smp_bin  = tag_pipe[RD_LAT];
  assign bin_dist = smp_bin - addr1_q;
  assign sep_ok   = bin_dist >= 12'(MIN_SEP);

  always_comb begin
    amp1_d  = amp1_q;
    addr1_d = addr1_q;
    amp2_d  = amp2_q;
    addr2_d = addr2_q;
    if (vld_pipe[RD_LAT]) begin
      if (rd_data_i > amp1_q) begin
        if (sep_ok || amp1_q == 16'd0) begin
          amp2_d  = amp1_q;
          addr2_d = addr1_q;
        end
        amp1_d  = rd_data_i;
        addr1_d = smp_bin;
      end else if (rd_data_i > amp2_q && sep_ok) begin
        amp2_d  = rd_data_i;
        addr2_d = smp_bin;
      end
    end
  end

  // Anything still ahead of the final stage means more samples to come.
  always_comb begin
    inflight = rd_en_q;
    for (int i = 1; i < RD_LAT; i++) inflight = inflight | vld_pipe[i];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      wr_done_q  <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      busy_q     <= 1'b0;
      sep_done_q <= 1'b0;
      vld_pipe   <= '0;
      tag_pipe   <= '0;
      amp1_q     <= '0;
      addr1_q    <= '0;
      amp2_q     <= '0;
      addr2_q    <= '0;
      p1a_q      <= '0;
      p1v_q      <= '0;
      p2a_q      <= '0;
      p2v_q      <= '0;
    end else begin
      wr_done_q <= wr_done_i;
      for (int i = RD_LAT; i > 1; i--) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
      vld_pipe[1] <= rd_en_q;
      tag_pipe[1] <= rd_addr_q;
      amp1_q  <= amp1_d;
      addr1_q <= addr1_d;
      amp2_q  <= amp2_d;
      addr2_q <= addr2_d;
      case (state_q)
        IDLE: if (wr_done_i && !wr_done_q) state_q <= READ;
        READ, DRAIN: begin
          if (!wr_done_i) begin
            // Write side withdrew the spectrum: drop everything in flight.
            state_q  <= IDLE;
            rd_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            vld_pipe <= '0;
            amp1_q   <= '0;
            addr1_q  <= '0;
            amp2_q   <= '0;
            addr2_q  <= '0;
          end else if (state_q == READ) begin
            if (!rd_en_q) begin
              rd_en_q   <= 1'b1;
              rd_addr_q <= 12'(START_BIN);
              busy_q    <= 1'b1;
            end else if (rd_addr_q == 12'(END_BIN - 1)) begin
              rd_en_q <= 1'b0;
              state_q <= DRAIN;
            end else begin
              rd_addr_q <= rd_addr_q + 12'd1;
            end
          end else if (!inflight) begin
            // Last sample is being folded in this edge, so publish the _d view.
            state_q    <= DONE;
            p1a_q      <= addr1_d;
            p1v_q      <= amp1_d;
            p2a_q      <= addr2_d;
            p2v_q      <= amp2_d;
            sep_done_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_en_o      = rd_en_q;
  assign rd_addr_o    = rd_addr_q;
  assign peak1_addr_o = p1a_q;
  assign peak1_amp_o  = p1v_q;
  assign peak2_addr_o = p2a_q;
  assign peak2_amp_o  = p2v_q;
  assign busy_o       = busy_q;
  assign sep_done_o   = sep_done_q;

endmodule

// File: tb/tb_spec_peak_scan_ctrl.sv
// Directed bench: three builds (RD_LAT 2, 1, 4) share one spectrum RAM image.
module tb_spec_peak_scan_ctrl;
  localparam int NI = 3;
  localparam int N  = 2048 - 5;

  logic clk = 1'b0, rst_n = 1'b0, wr_done = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [4096];
  logic        rd_en   [NI];
  logic [11:0] rd_addr [NI];
  logic [15:0] rd_data [NI];
  logic [11:0] p1a [NI], p2a [NI];
  logic [15:0] p1v [NI], p2v [NI];
  logic        busy [NI], done [NI];

  int checks = 0, errors = 0;

  function automatic int lat_of(int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 4);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    logic [15:0] st [LAT];
    always @(posedge clk) begin
      st[0] <= mem[rd_addr[g]];
      for (int i = 1; i < LAT; i++) st[i] <= st[i-1];
    end
    assign rd_data[g] = st[LAT-1];

    spec_peak_scan_ctrl #(.END_BIN(2048), .START_BIN(5), .MIN_SEP(8), .RD_LAT(LAT)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .wr_done_i(wr_done),
      .rd_en_o(rd_en[g]), .rd_addr_o(rd_addr[g]), .rd_data_i(rd_data[g]),
      .peak1_addr_o(p1a[g]), .peak1_amp_o(p1v[g]),
      .peak2_addr_o(p2a[g]), .peak2_amp_o(p2v[g]),
      .busy_o(busy[g]), .sep_done_o(done[g])
    );
  end

  typedef struct packed {
    logic [3:0][11:0] bin;
    logic [3:0][15:0] amp;
    logic [11:0]      p1a;
    logic [15:0]      p1v;
    logic [11:0]      p2a;
    logic [15:0]      p2v;
  } vec_t;

  vec_t tbl [9];

  function automatic vec_t mk(int b0, int a0, int b1, int a1, int b2, int a2, int b3, int a3,
                              int e1a, int e1v, int e2a, int e2v);
    vec_t v;
    v.bin = {12'(b3), 12'(b2), 12'(b1), 12'(b0)};
    v.amp = {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    v.p1a = 12'(e1a); v.p1v = 16'(e1v);
    v.p2a = 12'(e2a); v.p2v = 16'(e2v);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Bins outside the scanned range carry 0xFFFF so a stray read would win.
  task automatic load(input vec_t v);
    for (int i = 0; i < 4096; i++) mem[i] = 16'd0;
    mem[0] = 16'hFFFF; mem[4] = 16'hFFFF; mem[2048] = 16'hFFFF; mem[4095] = 16'hFFFF;
    for (int j = 0; j < 4; j++) if (v.amp[j] != 16'd0) mem[v.bin[j]] = v.amp[j];
  endtask

  task automatic out_zero(input string name);
    int acc;
    acc = 0;
    for (int g = 0; g < NI; g++)
      acc += int'(rd_en[g]) + int'(rd_addr[g]) + int'(p1a[g]) + int'(p1v[g]) +
             int'(p2a[g]) + int'(p2v[g]) + int'(busy[g]) + int'(done[g]);
    chk(name, acc, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; wr_done = 1'b0;
    #1 out_zero("reset_outputs");
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge; the following posedge is cycle 0.
  task automatic run_scan(input string name, input vec_t v);
    int dc [NI];
    int exp_addr, bad;
    bit all;
    exp_addr = 5; bad = 0; all = 1'b0;
    for (int g = 0; g < NI; g++) dc[g] = -1;
    wr_done = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 2200 && !all; c++) begin
      @(posedge clk); #1;
      if (rd_en[0]) begin
        if (int'(rd_addr[0]) != exp_addr) bad++;
        exp_addr++;
      end
      if (c == 1) chk({name, "_busy_first"}, int'(busy[0]), 1);
      if (c == N) chk({name, "_peak_before_done"}, int'(p1v[0]) + int'(p1a[0]), 0);
      all = 1'b1;
      for (int g = 0; g < NI; g++) begin
        if (done[g] && dc[g] < 0) dc[g] = c;
        if (dc[g] < 0) all = 1'b0;
      end
    end
    chk({name, "_addr_seq"}, bad, 0);
    chk({name, "_reads"}, exp_addr - 5, N);
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("%s_done_cyc_lat%0d", name, lat_of(g)), dc[g], N + lat_of(g) + 1);
      chk($sformatf("%s_p1a_lat%0d", name, lat_of(g)), int'(p1a[g]), int'(v.p1a));
      chk($sformatf("%s_p1v_lat%0d", name, lat_of(g)), int'(p1v[g]), int'(v.p1v));
      chk($sformatf("%s_p2a_lat%0d", name, lat_of(g)), int'(p2a[g]), int'(v.p2a));
      chk($sformatf("%s_p2v_lat%0d", name, lat_of(g)), int'(p2v[g]), int'(v.p2v));
    end
    chk({name, "_busy_done"}, int'(busy[0]), 0);
  endtask

  initial begin
    tbl[0] = mk(100, 5000, 300, 3000, 0, 0, 0, 0,   100, 5000, 300, 3000);
    tbl[1] = mk(100, 5000, 104, 4900, 400, 1000, 0, 0, 100, 5000, 400, 1000);
    tbl[2] = mk(50, 1000, 52, 2000, 200, 1500, 0, 0, 52, 2000, 200, 1500);
    tbl[3] = mk(10, 7000, 900, 7000, 0, 0, 0, 0,    10, 7000, 900, 7000);
    tbl[4] = mk(0, 0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0);
    tbl[5] = mk(20, 100, 30, 200, 40, 300, 0, 0,    40, 300, 30, 200);
    tbl[6] = mk(5, 1, 2040, 9, 2047, 9, 0, 0,       2040, 9, 5, 1);
    tbl[7] = mk(1000, 50, 1007, 45, 1008, 40, 0, 0, 1000, 50, 1008, 40);
    tbl[8] = mk(600, 10, 700, 5, 800, 5, 0, 0,      600, 10, 700, 5);

    for (int i = 0; i < 9; i++) begin
      load(tbl[i]);
      do_reset();
      run_scan($sformatf("vec%0d", i), tbl[i]);
    end

    // Asynchronous reset in the middle of a sweep, then a clean rescan.
    load(tbl[0]);
    do_reset();
    wr_done = 1'b1;
    repeat (500) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 out_zero("midscan_reset");
    wr_done = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    run_scan("after_reset", tbl[0]);

    // wr_done withdrawn mid-sweep aborts; trackers must not leak into the rescan.
    load(tbl[2]);
    do_reset();
    wr_done = 1'b1;
    repeat (300) @(posedge clk);
    @(negedge clk) wr_done = 1'b0;
    @(posedge clk); #1;
    chk("abort_rd_en", int'(rd_en[0]), 0);
    chk("abort_busy", int'(busy[0]), 0);
    repeat (20) @(posedge clk);
    #1 chk("abort_no_done", int'(done[0]) + int'(done[1]) + int'(done[2]), 0);
    @(negedge clk);
    run_scan("after_abort", tbl[2]);

    // A fresh wr_done edge while results are held must be ignored.
    @(negedge clk) wr_done = 1'b0;
    @(negedge clk) wr_done = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("done_hold_rd_en", int'(rd_en[0]), 0);
    chk("done_hold_sep", int'(done[0]), 1);
    chk("done_hold_p1a", int'(p1a[0]), 52);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
